// File: rtl/ttl_pkg.sv
// Shared constants for the 74163 counter family models.
// Kept tiny on purpose: slice width, terminal count and the nibble step.
package ttl_pkg;

  localparam int unsigned    TTL_NIBBLE = 4;
  localparam logic [3:0]     TTL_TC     = 4'hF;

  // Next count of one package; the 4-bit result wraps 15 -> 0 by construction.
  function automatic logic [TTL_NIBBLE-1:0] ttl_nibble_inc(input logic [TTL_NIBBLE-1:0] value);
    logic [TTL_NIBBLE-1:0] sum;
    sum = value + 4'h1;
    return sum;
  endfunction

endpackage

// File: rtl/ttl_74163_stage.sv
// One 74163 package: 4-bit synchronous binary counter with synchronous clear.
// RCO is combinational from the registered count and the ENT input.
module ttl_74163_stage
  import ttl_pkg::*;
(
  input  logic                  CLK,
  input  logic                  CLR_n,
  input  logic                  LOAD_n,
  input  logic                  ENP,
  input  logic                  ENT,
  input  logic [TTL_NIBBLE-1:0] D,
  output logic [TTL_NIBBLE-1:0] Q,
  output logic                  RCO
);

  logic [TTL_NIBBLE-1:0] q_d;
  logic [TTL_NIBBLE-1:0] q_q;
  logic                  rco_s;

  // Load beats counting; ENP and ENT must both be high to advance.
  always_comb begin
    q_d = q_q;
    if (!LOAD_n) begin
      q_d = D;
    end else if (ENP && ENT) begin
      q_d = ttl_nibble_inc(q_q);
    end else begin
      q_d = q_q;
    end
  end

  // Count register; the clear is sampled on the clock edge like the real part.
  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      q_q <= 4'h0;
    end else begin
      q_q <= q_d;
    end
  end

  // Carry ignores ENP so a cascade can look ahead while paused.
  always_comb begin
    rco_s = 1'b0;
    if (ENT && (q_q == TTL_TC)) begin
      rco_s = 1'b1;
    end else begin
      rco_s = 1'b0;
    end
  end

  assign Q   = q_q;
  assign RCO = rco_s;

endmodule

// File: rtl/ttl_74163.sv
// N cascaded 74163 packages with RCO of each stage driving ENT of the next,
// so the whole 4*STAGES counter steps by one per enabled edge.
module ttl_74163
  import ttl_pkg::*;
#(
  parameter int unsigned STAGES = 1
) (
  input  logic                           CLK,
  input  logic                           CLR_n,
  input  logic                           LOAD_n,
  input  logic                           ENP,
  input  logic                           ENT,
  input  logic [TTL_NIBBLE*STAGES-1:0]   D,
  output logic [TTL_NIBBLE*STAGES-1:0]   Q,
  output logic [STAGES-1:0]              RCO
);

  logic [STAGES-1:0] ent_s;
  logic [STAGES-1:0] rco_s;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign ent_s[i] = ENT;
    end else begin : g_chain
      assign ent_s[i] = rco_s[i-1];
    end

    ttl_74163_stage u_stage (
      .CLK    (CLK),
      .CLR_n  (CLR_n),
      .LOAD_n (LOAD_n),
      .ENP    (ENP),
      .ENT    (ent_s[i]),
      .D      (D[TTL_NIBBLE*i +: TTL_NIBBLE]),
      .Q      (Q[TTL_NIBBLE*i +: TTL_NIBBLE]),
      .RCO    (rco_s[i])
    );
  end

  assign RCO = rco_s;

endmodule
